dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
- Sits between the pipelined CPU's data-memory port and the word-wide data SRAM. The SRAM has asynchronous read, synchronous write and no byte enables.
- Converts byte, halfword and word load/store requests into SRAM accesses. Sub-word stores use a read-modify-write. Sub-word loads are sign- or zero-extended.
- Uses a valid/ready request handshake and a one-cycle response pulse so the CPU can stall its memory stage.
- Drives the SRAM write enable only on real writes. Loads never assert it.

Parameters:
- ADDR_W, 11, SRAM word-address width; the SRAM port is ram_a[ADDR_W-1:0], driven from byte address [ADDR_W+1:2].
- DATA_W, 32, data width; fixed at 32, and other values are unsupported.

Ports:
- clk_in  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req_valid  in  1  request present.
- cpu_req_ready  out  1  bridge can accept a request.
- cpu_req_we  in  1  1 = store, 0 = load.
- cpu_req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- cpu_req_unsigned  in  1  zero-extend the load result, otherwise sign-extend.
- cpu_req_addr  in  32  byte address.
- cpu_req_wdata  in  32  store data, right-aligned.
- cpu_rsp_valid  out  1  one-cycle completion pulse.
- cpu_rsp_rdata  out  32  extended load data; 0 for stores.
- cpu_rsp_err  out  1  misaligned or reserved request (only when DMEM_ALIGN_CHECK_EN is defined).
- ram_a  out  ADDR_W  SRAM word address.
- ram_d  out  32  SRAM write data.
- ram_we  out  1  SRAM write enable.
- ram_rdata  in  32  SRAM asynchronous read data.

Behaviour:
- FSM states: IDLE, MERGE, RESP.
- Reset: state IDLE; cpu_req_ready=1; cpu_rsp_valid=0; cpu_rsp_rdata=0; cpu_rsp_err=0; ram_we=0; ram_a=0; ram_d=0.
- A request is accepted only when cpu_req_valid and cpu_req_ready are both 1. cpu_req_ready=1 only in IDLE.
- Request fields are sampled at acceptance and do not need to be held afterwards.
- IDLE, load accepted:
  - ram_a comes combinationally from cpu_req_addr.
  - The byte/half lane of ram_rdata is selected by addr[1:0] (halfword by addr[1]) and extended.
  - The result is registered into cpu_rsp_rdata; next state RESP.
- IDLE, word store accepted: ram_we=1 in the same cycle with ram_d=wdata; next state RESP.
- IDLE, byte/half store accepted: latch addr, size and wdata; next state MERGE; ram_we=0.
- MERGE:
  - ram_a comes from the latched address.
  - ram_d = ram_rdata with the addressed lane replaced by wdata[7:0] or wdata[15:0].
  - ram_we=1 for exactly one cycle; next state RESP.
- RESP: cpu_rsp_valid=1 for one cycle; next state IDLE.
- Latency from acceptance to cpu_rsp_valid:
  - load: 1 cycle;
  - word store: 1 cycle;
  - sub-word store: 2 cycles.
- Throughput: at most one request every 2 cycles (3 for sub-word stores).
- Outside MERGE and the word-store accept cycle, ram_we=0.
- Address bits above ADDR_W+1 are ignored, so accesses wrap within the SRAM.
- A load following a store always sees the stored data, because the store write completes before its response.
- Reset asserted in any state returns the FSM to IDLE at that edge:
  - no write is issued in the reset cycle;
  - a pending MERGE is discarded;
  - no response is produced.
- cpu_req_valid asserted outside IDLE has no effect; the request waits.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined:
  - Misaligned requests (half with addr[0]=1; word with addr[1:0]≠0) and size 11 are flagged.
  - Flagged requests go IDLE→RESP with cpu_rsp_err=1 and cpu_rsp_rdata=0.
  - No SRAM write is issued for a flagged request.
- Undefined:
  - cpu_rsp_err is tied to 0.
  - The unused low address bits are ignored: a halfword uses addr[1] only, a word ignores [1:0].
  - Size 11 is treated as word.

Decomposition:
- Package dmem_pkg contains:
  - size localparams SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - FSM state encodings S_IDLE, S_MERGE, S_RESP.
- One sub-module, dmem_lane_align: purely combinational.
  - Load path: lane extract and extend, from (word, addr[1:0], size, unsigned).
  - Store path: lane merge, from (old word, new data, addr[1:0], size).
  - Instantiated once for each path.

Test Plan:
- Word store then word load: SW 0xDEADBEEF @0x10, then LW @0x10 → ram_we high one cycle at ram_a=4; load rsp_rdata=0xDEADBEEF one cycle after accept.
- Byte RMW: word @0x20 holds 0x11223344; SB 0xAA @0x21 → rsp 2 cycles after accept; word becomes 0x1122AA44. Then LB @0x21 → 0xFFFFFFAA; LBU @0x21 → 0x000000AA.
- Halfword: SH 0x8001 @0x32 on 0 → word 0x80010000. LH @0x32 → 0xFFFF8001; LHU @0x32 → 0x00008001.
- Handshake: valid held high for back-to-back loads → ready low in RESP; a second accept no earlier than 2 cycles after the first; ram_we never asserted during loads.
- Reset in MERGE: reset asserted the cycle after an SB accept → no ram_we; no rsp_valid; state IDLE and ready=1 the next cycle; memory unchanged.
- DMEM_ALIGN_CHECK_EN: SW @0x13 → rsp_err=1, rsp_rdata=0, no write. Without the macro, the same SW writes word address 4.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size codes, FSM states and the alignment predicate for the data-memory bridge.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_MERGE = 2'b01,
        S_RESP  = 2'b10
    } state_e;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_RSVD) || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational lane logic; STORE=0 extracts and extends a load lane,
// STORE=1 merges right-aligned store data into the addressed lane of the old word.
import dmem_pkg::*;

module dmem_lane_align #(
    parameter bit STORE = 1'b0
) (
    input  logic [31:0] word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] res_o
);

    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ld, rep, mask;

    always_comb begin
        b    = word_i[{off_i, 3'b000} +: 8];
        h    = off_i[1] ? word_i[31:16] : word_i[15:0];
        ld   = size_i == SZ_BYTE ? {{24{b[7] & ~uns_i}}, b} :
               size_i == SZ_HALF ? {{16{h[15] & ~uns_i}}, h} : word_i;
        // Replicate the store data across lanes, then keep only the addressed lane.
        rep  = size_i == SZ_BYTE ? {4{data_i[7:0]}} :
               size_i == SZ_HALF ? {2{data_i[15:0]}} : data_i;
        mask = size_i == SZ_BYTE ? 32'hFF << {off_i, 3'b000} :
               size_i == SZ_HALF ? (off_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : 32'hFFFF_FFFF;
        res_o = STORE ? (word_i & ~mask) | (rep & mask) : ld;
    end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: CPU load/store port to word-wide async-read SRAM, with read-modify-write for sub-word stores.
// Optional DMEM_ALIGN_CHECK_EN flags misaligned/reserved requests with cpu_rsp_err instead of accessing memory.
import dmem_pkg::*;

module dmem_bridge #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [1:0]        cpu_req_size,
    input  logic              cpu_req_unsigned,
    input  logic [31:0]       cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_rsp_valid,
    output logic [DATA_W-1:0] cpu_rsp_rdata,
    output logic              cpu_rsp_err,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_e            state_q;
    logic              ready_q, rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q, wdata_q, ld_data, mrg_data;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic              accept, flag, wr_word, merge_we, unused;

    assign cpu_req_ready = ready_q;
    assign cpu_rsp_valid = rsp_valid_q;
    assign cpu_rsp_rdata = rsp_rdata_q;
    assign cpu_rsp_err   = rsp_err_q;

`ifdef DMEM_ALIGN_CHECK_EN
    assign flag = misaligned(cpu_req_size, cpu_req_addr[1:0]);
`else
    assign flag = 1'b0;
`endif

    // High address bits wrap within the SRAM.
    assign unused = ^cpu_req_addr[31:ADDR_W+2];

    // Reset gates every write-side signal so nothing reaches the SRAM in the reset cycle.
    assign accept   = cpu_req_valid && ready_q && !reset;
    assign wr_word  = accept && cpu_req_we && cpu_req_size[1] && !flag;
    assign merge_we = state_q == S_MERGE && !reset;
    assign ram_we   = wr_word || merge_we;
    assign ram_a    = merge_we ? addr_q[ADDR_W+1:2] : accept ? cpu_req_addr[ADDR_W+1:2] : '0;
    assign ram_d    = wr_word ? cpu_req_wdata : merge_we ? mrg_data : '0;

    dmem_lane_align #(.STORE(1'b0)) u_load (
        .word_i (ram_rdata),
        .data_i ('0),
        .off_i  (cpu_req_addr[1:0]),
        .size_i (cpu_req_size),
        .uns_i  (cpu_req_unsigned),
        .res_o  (ld_data)
    );

    dmem_lane_align #(.STORE(1'b1)) u_store (
        .word_i (ram_rdata),
        .data_i (wdata_q),
        .off_i  (addr_q[1:0]),
        .size_i (size_q),
        .uns_i  (1'b0),
        .res_o  (mrg_data)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    ready_q     <= 1'b0;
                    rsp_err_q   <= flag;
                    rsp_rdata_q <= (cpu_req_we || flag) ? '0 : ld_data;
                    addr_q      <= cpu_req_addr[ADDR_W+1:0];
                    size_q      <= cpu_req_size;
                    wdata_q     <= cpu_req_wdata;
                    if (cpu_req_we && !cpu_req_size[1] && !flag) begin
                        state_q <= S_MERGE;
                    end else begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                S_MERGE: begin
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    ready_q     <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed checks of dmem_bridge against a behavioural SRAM model.
// Honours DMEM_ALIGN_CHECK_EN for the misaligned-store expectation.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        reset, valid, ready, we, uns, rsp_valid, rsp_err, ram_we;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rsp_rdata, ram_d, ram_rdata;
    logic [10:0] ram_a;
    logic [31:0] mem [0:2047];
    int          wr_cnt = 0;
    logic [10:0] last_wa = '0;
    logic [31:0] last_wd = '0;
    int          errs = 0, checks = 0;

    always #5 clk = ~clk;

    dmem_bridge dut (
        .clk_in           (clk),
        .reset            (reset),
        .cpu_req_valid    (valid),
        .cpu_req_ready    (ready),
        .cpu_req_we       (we),
        .cpu_req_size     (size),
        .cpu_req_unsigned (uns),
        .cpu_req_addr     (addr),
        .cpu_req_wdata    (wdata),
        .cpu_rsp_valid    (rsp_valid),
        .cpu_rsp_rdata    (rsp_rdata),
        .cpu_rsp_err      (rsp_err),
        .ram_a            (ram_a),
        .ram_d            (ram_d),
        .ram_we           (ram_we),
        .ram_rdata        (ram_rdata)
    );

    assign ram_rdata = mem[ram_a];

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_a] <= ram_d;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= ram_a;
            last_wd <= ram_d;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction; lat counts cycles from the accept edge to the response (8 = timed out).
    task automatic xfer(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic er);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 8) begin @(negedge clk); n++; end
        valid = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
        @(posedge clk); #1;
        valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin @(posedge clk); #1; lat++; end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    initial begin
        int          lat, w0;
        logic [31:0] rd;
        logic        er;
        logic [5:0]  rdy;
        reset = 1'b1; valid = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_a", 32'(ram_a), 32'd0);
        chk("rst_ram_d", ram_d, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        w0 = wr_cnt;
        xfer(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, lat, rd, er);
        chk("sw_lat", 32'(lat), 32'd1);
        chk("sw_writes", 32'(wr_cnt - w0), 32'd1);
        chk("sw_addr", 32'(last_wa), 32'd4);
        chk("sw_data", last_wd, 32'hDEADBEEF);
        chk("sw_rdata", rd, 32'h0);

        w0 = wr_cnt;
        xfer(0, 2'b10, 0, 32'h10, 32'h0, lat, rd, er);
        chk("lw_lat", 32'(lat), 32'd1);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_no_write", 32'(wr_cnt - w0), 32'd0);

        xfer(1, 2'b10, 0, 32'h20, 32'h11223344, lat, rd, er);
        w0 = wr_cnt;
        xfer(1, 2'b00, 0, 32'h21, 32'h000000AA, lat, rd, er);
        chk("sb_lat", 32'(lat), 32'd2);
        chk("sb_writes", 32'(wr_cnt - w0), 32'd1);
        chk("sb_mem", mem[8], 32'h1122AA44);
        xfer(0, 2'b00, 0, 32'h21, 32'h0, lat, rd, er);
        chk("lb", rd, 32'hFFFFFFAA);
        xfer(0, 2'b00, 1, 32'h21, 32'h0, lat, rd, er);
        chk("lbu", rd, 32'h000000AA);

        xfer(1, 2'b10, 0, 32'h30, 32'h0, lat, rd, er);
        xfer(1, 2'b01, 0, 32'h32, 32'h00008001, lat, rd, er);
        chk("sh_lat", 32'(lat), 32'd2);
        chk("sh_mem", mem[12], 32'h80010000);
        xfer(0, 2'b01, 0, 32'h32, 32'h0, lat, rd, er);
        chk("lh", rd, 32'hFFFF8001);
        xfer(0, 2'b01, 1, 32'h32, 32'h0, lat, rd, er);
        chk("lhu", rd, 32'h00008001);

        // Valid held high: accepts land every other cycle.
        @(negedge clk);
        while (!ready) @(negedge clk);
        w0 = wr_cnt;
        valid = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h10;
        for (int c = 0; c < 6; c++) begin
            rdy[c] = ready;
            @(negedge clk);
        end
        valid = 1'b0;
        chk("b2b_ready_pattern", 32'(rdy), 32'h15);
        chk("b2b_no_write", 32'(wr_cnt - w0), 32'd0);

        // Reset during MERGE discards the pending write.
        xfer(1, 2'b10, 0, 32'h40, 32'h55667788, lat, rd, er);
        @(negedge clk);
        while (!ready) @(negedge clk);
        w0 = wr_cnt;
        valid = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h40; wdata = 32'h99;
        @(posedge clk); #1;
        valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rstm_ram_we", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rstm_ready", 32'(ready), 32'd1);
        chk("rstm_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("rstm_rsp_valid2", 32'(rsp_valid), 32'd0);
        chk("rstm_writes", 32'(wr_cnt - w0), 32'd0);
        chk("rstm_mem", mem[16], 32'h55667788);

        // High address bits wrap.
        w0 = wr_cnt;
        xfer(1, 2'b10, 0, 32'h8020, 32'h0BADC0DE, lat, rd, er);
        chk("wrap_addr", 32'(last_wa), 32'd8);
        xfer(0, 2'b10, 0, 32'h20, 32'h0, lat, rd, er);
        chk("wrap_read", rd, 32'h0BADC0DE);

        w0 = wr_cnt;
        xfer(1, 2'b10, 0, 32'h13, 32'hCAFEF00D, lat, rd, er);
        chk("mis_lat", 32'(lat), 32'd1);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_rdata", rd, 32'h0);
        chk("mis_writes", 32'(wr_cnt - w0), 32'd0);
        chk("mis_mem", mem[4], 32'hDEADBEEF);
`else
        chk("mis_err", 32'(er), 32'd0);
        chk("mis_writes", 32'(wr_cnt - w0), 32'd1);
        chk("mis_addr", 32'(last_wa), 32'd4);
        chk("mis_mem", mem[4], 32'hCAFEF00D);
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
